// File: rtl/game_ctrl.sv
// Stacking-game sequencer: button synchronisers, game FSM, catch/miss detection,
// score and lives bookkeeping. All outputs come straight from flops.
module game_ctrl #(
    parameter int LIVES   = 3,
    parameter int ITEM_W  = 16,
    parameter int ITEM_H  = 16,
    parameter int STACK_W = 48,
    parameter int FLOOR_Y = 480,
    parameter int CLR_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       fall_tick,
    input  logic [9:0] fall_x,
    input  logic [9:0] fall_y,
    input  logic [9:0] stack_x,
    input  logic [9:0] stack_top,
    output logic       dp_rst,
    output logic       run,
    output logic [2:0] state,
    output logic [9:0] score,
    output logic [1:0] lives,
    output logic       catch_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLR    = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        OVER   = 3'd4
    } state_e;

    localparam int CW = $clog2(CLR_CYC + 1);

    // [0],[1] synchroniser, [2] previous sample for the edge detector.
    // Preset high so a button held across reset release cannot look like a rising edge.
    logic [2:0] start_sync_q, pause_sync_q;
    logic       start_e, pause_e;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_sync_q <= '1;
            pause_sync_q <= '1;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start};
            pause_sync_q <= {pause_sync_q[1:0], pause};
        end
    end

    assign start_e = start_sync_q[1] & ~start_sync_q[2];
    assign pause_e = pause_sync_q[1] & ~pause_sync_q[2];

    logic [10:0] bottom;
    logic        overlap, catch_c, miss_c, rearm_c;

    assign bottom  = {1'b0, fall_y} + 11'(ITEM_H);
    assign overlap = (({1'b0, fall_x} + 11'(ITEM_W)) > {1'b0, stack_x}) &&
                     ({1'b0, fall_x} < ({1'b0, stack_x} + 11'(STACK_W)));
    assign catch_c = overlap && (bottom >= {1'b0, stack_top});
    assign miss_c  = !catch_c && (bottom >= 11'(FLOOR_Y));
    assign rearm_c = bottom < {1'b0, stack_top};

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic [9:0]  score_q;
    logic [1:0]  lives_q;
    logic        armed_q, catch_q, miss_q, dp_rst_q, run_q, over_q;
    logic        go_clr;

    // Start restarts from every state except CLR, and beats pause and any tick.
    assign go_clr = start_e && (state_q != CLR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            score_q  <= '0;
            lives_q  <= 2'(LIVES);
            armed_q  <= 1'b1;
            catch_q  <= 1'b0;
            miss_q   <= 1'b0;
            dp_rst_q <= 1'b1;
            run_q    <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            catch_q <= 1'b0;
            miss_q  <= 1'b0;
            if (go_clr) begin
                state_q  <= CLR;
                cnt_q    <= '0;
                score_q  <= '0;
                lives_q  <= 2'(LIVES);
                armed_q  <= 1'b1;
                dp_rst_q <= 1'b1;
                run_q    <= 1'b0;
                over_q   <= 1'b0;
            end else begin
                case (state_q)
                    CLR: begin
                        if (cnt_q == CW'(CLR_CYC - 1)) begin
                            state_q  <= PLAY;
                            dp_rst_q <= 1'b0;
                            run_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    PLAY: begin
                        if (pause_e) begin
                            state_q <= PAUSED;
                            run_q   <= 1'b0;
                        end else if (fall_tick) begin
                            if (armed_q) begin
                                if (catch_c) begin
                                    catch_q <= 1'b1;
                                    armed_q <= 1'b0;
                                    if (score_q != '1) score_q <= score_q + 1'b1;
                                end else if (miss_c) begin
                                    miss_q  <= 1'b1;
                                    armed_q <= 1'b0;
                                    if (lives_q > 2'd1) begin
                                        lives_q <= lives_q - 1'b1;
                                    end else begin
                                        lives_q <= 2'd0;
                                        state_q <= OVER;
                                        run_q   <= 1'b0;
                                        over_q  <= 1'b1;
                                    end
                                end
                            end else if (rearm_c) begin
                                armed_q <= 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (pause_e) begin
                            state_q <= PLAY;
                            run_q   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dp_rst      = dp_rst_q;
    assign run         = run_q;
    assign state       = state_q;
    assign score       = score_q;
    assign lives       = lives_q;
    assign catch_pulse = catch_q;
    assign miss_pulse  = miss_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: tick expectations go through a scoreboard queue.
module tb_game_ctrl;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0, fall_tick = 1'b0;
    logic [9:0] fall_x = '0, fall_y = '0, stack_x = '0, stack_top = '0;
    logic       dp_rst, run, catch_pulse, miss_pulse, game_over;
    logic [2:0] state;
    logic [9:0] score;
    logic [1:0] lives;

    game_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .fall_tick(fall_tick),
        .fall_x(fall_x), .fall_y(fall_y), .stack_x(stack_x), .stack_top(stack_top),
        .dp_rst(dp_rst), .run(run), .state(state), .score(score), .lives(lives),
        .catch_pulse(catch_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    st, sc, lv, cp, mp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_err = 0;
    int   exp_score = 0, exp_lives = 3;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold the buttons long enough to cross the synchroniser; returns one cycle after the FSM reacts.
    task automatic press(input logic s, input logic p);
        start = s;
        pause = p;
        step(2);
        start = 1'b0;
        pause = 1'b0;
        step(1);
    endtask

    task automatic wait_state(input int s, input int bound, input string tag);
        int n = 0;
        while (state !== 3'(s) && n < bound) begin
            step(1);
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".catch"}, catch_pulse, e.cp);
        chk({e.tag, ".miss"},  miss_pulse,  e.mp);
        chk({e.tag, ".score"}, score,       e.sc);
        chk({e.tag, ".lives"}, lives,       e.lv);
        chk({e.tag, ".state"}, state,       e.st);
    endtask

    // Drive one fall_tick; ecp/emp/est are the hand-derived outcomes for this geometry.
    task automatic tick(input string tag, input int fx, input int fy,
                        input int ecp, input int emp, input int est);
        exp_t e;
        fall_x    = 10'(fx);
        fall_y    = 10'(fy);
        fall_tick = 1'b1;
        if (ecp != 0 && exp_score < 1023) exp_score++;
        if (emp != 0 && exp_lives > 0) exp_lives--;
        e.tag = tag; e.st = est; e.sc = exp_score; e.lv = exp_lives; e.cp = ecp; e.mp = emp;
        exp_q.push_back(e);
        step(1);
        fall_tick = 1'b0;
        compare_out();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset with start held: must not produce an edge on release.
        start = 1'b1;
        step(3);
        chk("rst.state", state, 0);
        chk("rst.dp_rst", dp_rst, 1);
        chk("rst.run", run, 0);
        chk("rst.score", score, 0);
        chk("rst.lives", lives, 3);
        chk("rst.pulses", {catch_pulse, miss_pulse}, 0);
        chk("rst.game_over", game_over, 0);
        rst = 1'b1;
        step(5);
        chk("held_start.state", state, 0);
        start = 1'b0;
        step(3);

        press(1'b1, 1'b0);
        wait_state(1, 3, "start.clr");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("clr%0d.state", i), state, 1);
            chk($sformatf("clr%0d.dp_rst", i), dp_rst, 1);
            step(1);
        end
        chk("play.state", state, 2);
        chk("play.run", run, 1);
        chk("play.dp_rst", dp_rst, 0);
        chk("play.lives", lives, 3);
        chk("play.score", score, 0);

        stack_x   = 10'd100;
        stack_top = 10'd400;
        tick("catch1", 110, 384, 1, 0, 2);
        tick("repeat", 110, 384, 0, 0, 2);
        tick("rearm1", 110, 0,   0, 0, 2);

        press(1'b0, 1'b1);
        chk("pause.state", state, 3);
        chk("pause.run", run, 0);
        tick("paused_tick", 110, 384, 0, 0, 3);
        press(1'b0, 1'b1);
        chk("resume.state", state, 2);
        chk("resume.run", run, 1);

        for (int i = 0; i < 4; i++) begin
            tick("catchN", 110, 384, 1, 0, 2);
            tick("rearmN", 110, 0,   0, 0, 2);
        end
        chk("score5", score, 5);

        tick("nomiss384", 300, 384, 0, 0, 2);
        tick("nomiss400", 300, 400, 0, 0, 2);
        tick("miss1",     300, 464, 0, 1, 2);
        tick("rearm_m1",  300, 0,   0, 0, 2);
        tick("miss2",     300, 464, 0, 1, 2);
        tick("rearm_m2",  300, 0,   0, 0, 2);
        tick("miss3",     300, 464, 0, 1, 4);
        chk("over.game_over", game_over, 1);
        chk("over.run", run, 0);
        chk("over.score", score, 5);

        press(1'b0, 1'b1);
        chk("over_pause.state", state, 4);

        press(1'b1, 1'b1);
        wait_state(1, 3, "restart.clr");
        wait_state(2, 6, "restart.play");
        chk("restart.score", score, 0);
        chk("restart.lives", lives, 3);
        chk("restart.run", run, 1);
        exp_score = 0;
        exp_lives = 3;

        for (int i = 0; i < 1023; i++) begin
            tick("sat_c", 110, 384, 1, 0, 2);
            tick("sat_r", 110, 0,   0, 0, 2);
        end
        chk("sat.score", score, 1023);
        tick("sat_top", 110, 384, 1, 0, 2);
        step(1);
        chk("sat.pulse_drop", catch_pulse, 0);
        chk("sat.hold", score, 1023);

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst.state", state, 0);
        chk("async_rst.dp_rst", dp_rst, 1);
        chk("async_rst.run", run, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
